down_counter_n: RTL and testbench

DOWN_COUNTER_N -- requirements
Module: down_counter_n

---
 rtl/down_counter_n.sv | 128 ++++++++++++
 tb/tb_down_counter_n.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/down_counter_n.sv
// down_counter_n: loadable down-counter with an IDLE/RUN/DONE handshake FSM.
// The ripple-borrow decrement stops at zero and never wraps.
// Optional macro DOWN_COUNTER_AUTORELOAD_EN adds a reload register. With it,
// DONE restarts the count from the last loaded value, and only abort_in
// returns the block to IDLE.
module down_counter_n #(
    parameter int N = 5
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         load_valid_in,
    input  logic [N-1:0] load_value_in,
    output logic         load_ready_out,
    input  logic         en_in,
    input  logic         abort_in,
    output logic [N-1:0] count_out,
    output logic         busy_out,
    output logic         done_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [N-1:0] count_q, count_d;
    logic [N-1:0] borrow;
    logic [N-1:0] dec_val;
    logic         load_fire;

`ifdef DOWN_COUNTER_AUTORELOAD_EN
    logic [N-1:0] reload_q, reload_d;
`endif

    // Ripple borrow chain: bit 0 always toggles, bit i toggles when all lower bits are 0.
    assign borrow[0] = 1'b1;
    genvar gi;
    generate
        for (gi = 1; gi < N; gi++) begin : g_borrow
            assign borrow[gi] = borrow[gi-1] & ~count_q[gi-1];
        end
    endgenerate
    assign dec_val = count_q ^ borrow;

    // Outputs are pure decodes of the registered state.
    assign load_ready_out = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy_out       = (state_q == S_RUN);
    assign done_out       = (state_q == S_DONE);
    assign count_out      = count_q;

    // A load is accepted only when ready and not cancelled by abort in the same cycle.
    assign load_fire = load_valid_in && load_ready_out && !abort_in;

    // Next-state and count logic. Priority: abort, then load, then decrement.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        reload_d = reload_q;
`endif
        if (abort_in && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            count_d = '0;
        end else if (load_fire) begin
            state_d = S_RUN;
            count_d = load_value_in;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            reload_d = load_value_in;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Hold count; en_in and abort_in are ignored here.
                end
                S_RUN: begin
                    if (count_q == '0) begin
                        // A load of 0 finishes on the next edge without decrementing.
                        state_d = S_DONE;
                    end else if (en_in) begin
                        count_d = dec_val;
                        if (count_q == CNT_ONE) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
`ifdef DOWN_COUNTER_AUTORELOAD_EN
                    state_d = S_RUN;
                    count_d = reload_q;
`else
                    state_d = S_IDLE;
`endif
                end
                default: begin
                    state_d = S_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

`ifdef DOWN_COUNTER_AUTORELOAD_EN
    // Reload register holds the most recently loaded start value.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

endmodule

// File: tb/tb_down_counter_n.sv
// Testbench for down_counter_n. A behavioural model predicts the outputs after
// each edge and queues the prediction. A monitor compares each queued entry
// against the DUT just after the clock edge.
module tb_down_counter_n;

    localparam int N   = 5;
    localparam int MAX = (1 << N) - 1;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         load_valid_in;
    logic [N-1:0] load_value_in;
    logic         load_ready_out;
    logic         en_in;
    logic         abort_in;
    logic [N-1:0] count_out;
    logic         busy_out;
    logic         done_out;

    down_counter_n #(.N(N)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .load_valid_in (load_valid_in),
        .load_value_in (load_value_in),
        .load_ready_out(load_ready_out),
        .en_in         (en_in),
        .abort_in      (abort_in),
        .count_out     (count_out),
        .busy_out      (busy_out),
        .done_out      (done_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int cnt;
        bit busy;
        bit done;
        bit rdy;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Model state: phase 0 = idle, 1 = counting, 2 = terminal-count cycle.
    int m_phase  = 0;
    int m_cnt    = 0;
    int m_reload = 0;

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // Apply one edge of the specification's rules to the model.
    task automatic model_step(input bit lv, input int val, input bit en, input bit ab);
        bit rdy;
        rdy = (m_phase != 1);
        if (m_phase != 0 && ab) begin
            m_phase = 0;
            m_cnt   = 0;
        end else if (rdy && lv && !ab) begin
            m_phase  = 1;
            m_cnt    = val;
            m_reload = val;
        end else if (m_phase == 1) begin
            if (m_cnt == 0) begin
                m_phase = 2;
            end else if (en) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) m_phase = 2;
            end
        end else if (m_phase == 2) begin
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            m_phase = 1;
            m_cnt   = m_reload;
`else
            m_phase = 0;
`endif
        end
    endtask

    // Drive one cycle of inputs and queue the prediction for the following edge.
    task automatic cyc(input bit lv, input int val, input bit en, input bit ab);
        exp_t e;
        @(negedge clk_in);
        load_valid_in = lv;
        load_value_in = N'(val);
        en_in         = en;
        abort_in      = ab;
        model_step(lv, val, en, ab);
        e.cnt  = m_cnt;
        e.busy = (m_phase == 1);
        e.done = (m_phase == 2);
        e.rdy  = (m_phase != 1);
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, int'(count_out), 0);
        check({tag, "_busy"},  int'(busy_out), 0);
        check({tag, "_done"},  int'(done_out), 0);
        check({tag, "_ready"}, int'(load_ready_out), 1);
    endtask

    // Monitor: compare DUT outputs against the oldest prediction after each edge.
    exp_t mon_e;
    always @(posedge clk_in) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("count", int'(count_out), mon_e.cnt);
            check("busy",  int'(busy_out), int'(mon_e.busy));
            check("done",  int'(done_out), int'(mon_e.done));
            check("ready", int'(load_ready_out), int'(mon_e.rdy));
        end
    end

    initial begin
        int sel;
        int v;
        rst_in        = 1'b1;
        load_valid_in = 1'b0;
        load_value_in = '0;
        en_in         = 1'b0;
        abort_in      = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Load 5 with enable held high, then let the block settle.
        cyc(1, 5, 1, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0);
        if (m_phase != 0) cyc(1, 0, 0, 1);

        // Load 3 with the enable toggling.
        cyc(1, 3, 0, 0);
        cyc(0, 0, 1, 0); cyc(0, 0, 0, 0); cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0); cyc(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        if (m_phase != 0) cyc(1, 0, 0, 1);

        // Load 0, then load of the maximum value.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        if (m_phase != 0) cyc(1, 0, 0, 1);
        cyc(1, MAX, 1, 0);
        for (int i = 0; i < MAX + 2; i++) cyc(0, 0, 1, 0);
        if (m_phase != 0) cyc(1, 0, 0, 1);

        // Load 4, abort at count 2 while a load is presented.
        cyc(1, 4, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(1, 9, 1, 1);
        cyc(0, 0, 1, 0);

        // Load 2, then load 7 during DONE for back-to-back operation.
        cyc(1, 2, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(1, 7, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);

        // Assert reset asynchronously in mid-count.
        @(negedge clk_in);
        load_valid_in = 1'b0;
        en_in         = 1'b1;
        abort_in      = 1'b0;
        #2;
        rst_in = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk_in);
        rst_in  = 1'b0;
        m_phase = 0;
        m_cnt   = 0;
        m_reload = 0;
        cyc(0, 0, 1, 1);

`ifdef DOWN_COUNTER_AUTORELOAD_EN
        // Periodic operation: load 3, run for several periods, then abort.
        cyc(1, 3, 1, 0);
        for (int i = 0; i < 14; i++) cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 0);
`endif

        // Randomized traffic with a bias toward the boundary values.
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       v = 0;
                1:       v = 1;
                2:       v = MAX;
                default: v = int'($urandom_range(0, MAX));
            endcase
            cyc(($urandom_range(0, 3) == 0), v, ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 15) == 0));
        end

        // Drain the queue with a bounded wait.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk_in);
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
